// File: rtl/moxie_ifetch_wb.sv
// +----------------------------------------------------------------------------+
// | moxie_ifetch_wb: Wishbone instruction-fetch master with address-tagged     |
// | prefetch FIFO and branch flush.                                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module moxie_ifetch_wb #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h00001000
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      branch_i,
   input  logic [ADDR_WIDTH-1:0]     branch_target_i,
   input  logic                      pop_i,
   output logic                      valid_o,
   output logic [DATA_WIDTH-1:0]     data_o,
   output logic [ADDR_WIDTH-1:0]     addr_o,
   output logic [$clog2(DEPTH):0]    count_o,
   output logic                      err_o,
   output logic [ADDR_WIDTH-1:0]     wb_adr_o,
   output logic                      wb_cyc_o,
   output logic                      wb_stb_o,
   output logic                      wb_we_o,
   output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
   input  logic [DATA_WIDTH-1:0]     wb_dat_i,
   input  logic                      wb_ack_i,
   input  logic                      wb_err_i
);

   localparam int                    PW   = $clog2(DEPTH);
   localparam int                    CW   = PW + 1;
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
   localparam logic [CW-1:0]         FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
   logic                   stb_q, stb_d;
   logic                   err_q, err_d;
   logic [CW-1:0]          count_q, count_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [DATA_WIDTH-1:0]  data_mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0]  addr_mem_q [DEPTH];

   logic                   push, clear, pop_ok, term;
   logic [CW-1:0]          cnt_pop;
   logic                   room_idle, room_after;

   assign pop_ok     = pop_i && (count_q != '0);
   assign term       = stb_q && (wb_ack_i || wb_err_i);
   assign cnt_pop    = count_q - CW'(pop_ok);
   assign room_idle  = cnt_pop < FULL;
   assign room_after = (cnt_pop + CW'(1)) < FULL;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      adr_d   = adr_q;
      stb_d   = stb_q;
      err_d   = 1'b0;
      push    = 1'b0;
      clear   = 1'b0;
      case (state_q)
         IDLE: begin
            if (branch_i) begin
               clear   = 1'b1;
               pc_d    = branch_target_i;
               adr_d   = branch_target_i;
               stb_d   = 1'b1;
               state_d = BUSY;
            end else if (room_idle) begin
               adr_d   = pc_q;
               stb_d   = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (branch_i) begin
               clear = 1'b1;
               pc_d  = branch_target_i;
               if (term) begin
                  stb_d   = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = FLUSH;
               end
            end else if (term) begin
               if (wb_ack_i) begin
                  push = 1'b1;
                  pc_d = pc_q + STEP;
                  // Keep the strobe up for back-to-back fetch only if the slot is guaranteed.
                  if (room_after) begin
                     adr_d = pc_q + STEP;
                  end else begin
                     stb_d   = 1'b0;
                     state_d = IDLE;
                  end
               end else begin
                  err_d   = 1'b1;
                  stb_d   = 1'b0;
                  state_d = HALT;
               end
            end
         end
         FLUSH: begin
            if (branch_i) begin
               clear = 1'b1;
               pc_d  = branch_target_i;
            end
            if (term) begin
               stb_d   = 1'b0;
               state_d = IDLE;
            end
         end
         HALT: begin
            if (branch_i) begin
               clear   = 1'b1;
               pc_d    = branch_target_i;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (clear) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         count_d  = count_q + CW'(push) - CW'(pop_ok);
         rd_ptr_d = rd_ptr_q + PW'(pop_ok);
         wr_ptr_d = wr_ptr_q + PW'(push);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         adr_q    <= RESET_PC;
         stb_q    <= 1'b0;
         err_q    <= 1'b0;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_mem_q[i] <= '0;
            addr_mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         adr_q    <= adr_d;
         stb_q    <= stb_d;
         err_q    <= err_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         if (push) begin
            data_mem_q[wr_ptr_q] <= wb_dat_i;
            addr_mem_q[wr_ptr_q] <= adr_q;
         end
      end
   end

   assign valid_o  = (count_q != '0);
   assign data_o   = data_mem_q[rd_ptr_q];
   assign addr_o   = addr_mem_q[rd_ptr_q];
   assign count_o  = count_q;
   assign err_o    = err_q;
   assign wb_adr_o = adr_q;
   assign wb_cyc_o = stb_q;
   assign wb_stb_o = stb_q;
   assign wb_we_o  = 1'b0;
   assign wb_sel_o = '1;

endmodule

`default_nettype wire

// File: tb/tb_moxie_ifetch_wb.sv
// +----------------------------------------------------------------------------+
// | tb_moxie_ifetch_wb: randomized self-checking bench with a queue-based      |
// | transaction model of the fetch unit.                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_moxie_ifetch_wb;

   localparam int          AW       = 32;
   localparam int          DW       = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h00001000;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          branch_i;
   logic [AW-1:0] branch_target_i;
   logic          pop_i;
   logic          valid_o;
   logic [DW-1:0] data_o;
   logic [AW-1:0] addr_o;
   logic [2:0]    count_o;
   logic          err_o;
   logic [AW-1:0] wb_adr_o;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [3:0]    wb_sel_o;
   logic [DW-1:0] wb_dat_i;
   logic          wb_ack_i, wb_err_i;

   moxie_ifetch_wb #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .branch_i(branch_i),
      .branch_target_i(branch_target_i), .pop_i(pop_i), .valid_o(valid_o),
      .data_o(data_o), .addr_o(addr_o), .count_o(count_o), .err_o(err_o),
      .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: the FIFO as a queue plus a single outstanding request.
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_pc;
   logic [31:0] m_req;
   bit          m_open, m_stale, m_halt, m_err;

   task automatic model_reset();
      q.delete();
      m_pc = RESET_PC; m_req = RESET_PC;
      m_open = 0; m_stale = 0; m_halt = 0; m_err = 0;
   endtask

   task automatic model_step();
      bit term;
      term  = m_open && (wb_ack_i || wb_err_i);
      m_err = 0;
      if (branch_i) begin
         q.delete();
         m_pc = branch_target_i;
         if (m_open && !term) m_stale = 1;
         else if (m_open) begin m_open = 0; m_stale = 0; end
         else if (m_halt) m_halt = 0;
         else begin m_open = 1; m_req = branch_target_i; end
      end else begin
         if (pop_i && q.size() > 0) void'(q.pop_front());
         if (m_open && term) begin
            if (m_stale) begin
               m_open = 0; m_stale = 0;
            end else if (wb_ack_i) begin
               q.push_back({m_req, wb_dat_i});
               m_pc = m_pc + 32'd4;
               if (q.size() < DEPTH) m_req = m_pc;
               else m_open = 0;
            end else begin
               m_err = 1; m_open = 0; m_halt = 1;
            end
         end else if (!m_open && !m_halt && q.size() < DEPTH) begin
            m_open = 1; m_req = m_pc;
         end
      end
   endtask

   task automatic compare_all();
      chk("stb", 64'(wb_stb_o), 64'(m_open));
      chk("cyc", 64'(wb_cyc_o), 64'(m_open));
      if (m_open) chk("wb_adr", 64'(wb_adr_o), 64'(m_req));
      chk("count", 64'(count_o), 64'(q.size()));
      chk("valid", 64'(valid_o), 64'(q.size() != 0));
      if (q.size() != 0) begin
         chk("data", 64'(data_o), 64'(q[0].d));
         chk("addr", 64'(addr_o), 64'(q[0].a));
      end
      chk("err", 64'(err_o), 64'(m_err));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_stb"},   64'(wb_stb_o), 64'(0));
      chk({tag, "_cyc"},   64'(wb_cyc_o), 64'(0));
      chk({tag, "_adr"},   64'(wb_adr_o), 64'(RESET_PC));
      chk({tag, "_count"}, 64'(count_o),  64'(0));
      chk({tag, "_valid"}, 64'(valid_o),  64'(0));
      chk({tag, "_err"},   64'(err_o),    64'(0));
      chk({tag, "_data"},  64'(data_o),   64'(0));
      chk({tag, "_addr"},  64'(addr_o),   64'(0));
      chk({tag, "_we"},    64'(wb_we_o),  64'(0));
      chk({tag, "_sel"},   64'(wb_sel_o), 64'(4'hF));
   endtask

   // Stimulus knobs
   int          maxw, pop_pct, br_pct, err_pct, sp_pct;
   logic [31:0] key;
   bit          br_force;
   logic [31:0] tgt_force;
   int          wait_left;
   bit          req_seen;

   function automatic logic [31:0] rand_target();
      if ($urandom_range(0, 3) == 0) return 32'hFFFFFFF0 + 32'($urandom_range(0, 3) * 4);
      return $urandom & 32'hFFFFFFFC;
   endfunction

   task automatic tick();
      @(negedge clk_i);
      wb_ack_i = 0; wb_err_i = 0;
      if (wb_stb_o) begin
         if (!req_seen) begin
            wait_left = $urandom_range(0, maxw);
            req_seen  = 1;
         end
         if (wait_left == 0) begin
            if (int'($urandom_range(0, 99)) < err_pct) wb_err_i = 1;
            else begin
               wb_ack_i = 1;
               wb_dat_i = wb_adr_o ^ key;
            end
            req_seen = 0;
         end else wait_left--;
      end else begin
         req_seen = 0;
         if (int'($urandom_range(0, 99)) < sp_pct) begin
            wb_ack_i = 1;
            wb_dat_i = $urandom;
         end
      end
      pop_i    = int'($urandom_range(0, 99)) < pop_pct;
      branch_i = br_force || (int'($urandom_range(0, 99)) < br_pct);
      branch_target_i = br_force ? tgt_force : rand_target();
      br_force = 0;
      @(posedge clk_i);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic set_knobs(input int w, input int p, input int b, input int e, input int s);
      maxw = w; pop_pct = p; br_pct = b; err_pct = e; sp_pct = s;
   endtask

   initial begin
      rst_ni = 0; branch_i = 0; branch_target_i = '0; pop_i = 0;
      wb_dat_i = '0; wb_ack_i = 0; wb_err_i = 0;
      key = '0; br_force = 0; tgt_force = '0; wait_left = 0; req_seen = 0;
      model_reset();
      repeat (3) @(posedge clk_i);
      #1;
      check_reset_values("reset");
      rst_ni = 1;

      // Fill with a zero-wait slave and no consumer.
      set_knobs(0, 0, 0, 0, 0);
      repeat (12) tick();
      // Continuous consumer, zero-wait slave.
      set_knobs(0, 100, 0, 0, 0);
      repeat (40) tick();
      // Wrap across the top of the address space.
      br_force = 1; tgt_force = 32'hFFFFFFF8;
      set_knobs(0, 0, 0, 0, 0);
      repeat (10) tick();
      // Wait states, random consumer and branches, spurious terminations.
      key = $urandom;
      set_knobs(3, 50, 8, 0, 20);
      repeat (400) tick();
      // Bus errors mixed in; branches are the only way out of the halt.
      set_knobs(3, 40, 10, 10, 20);
      repeat (400) tick();

      // Asynchronous reset while a cycle is open.
      set_knobs(3, 0, 0, 0, 0);
      br_force = 1; tgt_force = 32'hFFFFFFF8;
      tick();
      chk("pre_reset_stb", 64'(wb_stb_o), 64'(1));
      #2 rst_ni = 0;
      #1 check_reset_values("async_reset");
      @(negedge clk_i);
      wb_ack_i = 1; wb_dat_i = 32'hDEADBEEF;
      @(posedge clk_i);
      #1 check_reset_values("late_ack");
      model_reset();
      req_seen = 0;
      rst_ni   = 1;

      set_knobs(2, 60, 6, 5, 10);
      repeat (400) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
